// File: rtl/adder_result_packer_if.sv
// Handshake bundle between the packer, the adder result FIFO and the host output FIFO.
interface adder_result_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic                  in_empty;
    logic                  in_rd;
    logic [DATA_WIDTH-1:0] in_din;
    logic                  out_full;
    logic                  out_wr;
    logic [DATA_WIDTH-1:0] out_dout;
    logic [LANES-1:0]      out_lane_mask;

    modport master (
        input  in_empty, in_din, out_full,
        output in_rd, out_wr, out_dout, out_lane_mask
    );

    modport slave (
        output in_empty, in_din, out_full,
        input  in_rd, out_wr, out_dout, out_lane_mask
    );
endinterface

// File: rtl/adder_result_packer.sv
// Packs the low lane of consecutive adder results into wide host words.
// Optional idle auto-flush of partial words: define PACKER_TIMEOUT_EN.
//   state | meaning
//   FILL  | popping results into the pack register
//   EMIT  | pack register complete (or flushed), waiting for host FIFO room
module adder_result_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int LANE_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    adder_result_packer_if.master bus,
    input  logic                  flush,
    output logic                  err_sticky,
    output logic [15:0]           packed_count
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    if ((DATA_WIDTH % LANE_WIDTH) != 0 || LANES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("adder_result_packer: unsupported DATA_WIDTH/LANE_WIDTH/TIMEOUT_CYCLES");
    end

    typedef enum logic {FILL, EMIT} state_t;

    state_t                state;
    logic [IDX_W-1:0]      lane_cnt;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [LANES-1:0]      mask_q;
    logic                  timeout_hit;
    logic                  flush_take;
    logic                  pop;
    logic                  emit;

    // A timeout is treated exactly like an external flush request.
    assign flush_take = (flush || timeout_hit) && (state == FILL) && (lane_cnt != '0);
    assign pop        = reset_n && (state == FILL) && !bus.in_empty && !flush_take;
    assign emit       = (state == EMIT) && !bus.out_full;
    assign bus.in_rd  = pop;

`ifdef PACKER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (pop || emit) begin
            idle_cnt <= '0;
        end else if ((state == FILL) && (lane_cnt != '0) && !flush_take) begin
            idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= FILL;
            lane_cnt          <= '0;
            pack_q            <= '0;
            mask_q            <= '0;
            err_sticky        <= 1'b0;
            packed_count      <= '0;
            bus.out_wr        <= 1'b0;
            bus.out_dout      <= '0;
            bus.out_lane_mask <= '0;
        end else begin
            bus.out_wr <= 1'b0;
            case (state)
                FILL: begin
                    if (flush_take) begin
                        state <= EMIT;
                    end else if (pop) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (lane_cnt == IDX_W'(k)) begin
                                pack_q[k*LANE_WIDTH +: LANE_WIDTH] <= bus.in_din[LANE_WIDTH-1:0];
                                mask_q[k]                          <= 1'b1;
                            end
                        end
                        lane_cnt <= lane_cnt + IDX_W'(1);
                        if (|bus.in_din[DATA_WIDTH-1:LANE_WIDTH]) begin
                            err_sticky <= 1'b1;
                        end
                        if (lane_cnt == IDX_W'(LANES - 1)) begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (emit) begin
                        bus.out_wr        <= 1'b1;
                        bus.out_dout      <= pack_q;
                        bus.out_lane_mask <= mask_q;
                        packed_count      <= packed_count + 16'd1;
                        lane_cnt          <= '0;
                        pack_q            <= '0;
                        mask_q            <= '0;
                        state             <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
